// File: rtl/if_id_ctrl.sv
// rtl/if_id_ctrl.sv - IF/ID pipeline register with hazard, redirect and freeze control
module if_id_ctrl #(
  parameter int addr_width = 32,
  parameter int word_width = 32,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] if_inst,
  input  logic [addr_width-1:0] if_pc,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_bch_taken,
  input  logic [addr_width-1:0] ex_bch_tgt,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  stall_en,
  output logic                  jmp_bch_en,
  output logic [addr_width-1:0] jmp_bch_tgt,
  output logic [word_width-1:0] id_inst,
  output logic [addr_width-1:0] id_pc,
  output logic                  id_valid,
  output logic                  ex_flush,
  output logic [cnt_width-1:0]  stall_cnt,
  output logic [cnt_width-1:0]  flush_cnt
);

  localparam logic [word_width-1:0] nop = word_width'(32'h0000_0013);

  typedef enum logic {RUN, PEND} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] pend_tgt_q, pend_tgt_d;
  logic [word_width-1:0] id_inst_q;
  logic [addr_width-1:0] id_pc_q;
  logic                  id_valid_q;
  logic [cnt_width-1:0]  stall_cnt_q, flush_cnt_q;

  logic lu;
  logic load_inst, load_bubble, stall_inc, flush_inc;

  assign lu = ex_mem_read && (ex_rd != 5'd0) && id_valid_q &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en       = 1'b1;
    stall_en    = 1'b0;
    jmp_bch_en  = 1'b0;
    jmp_bch_tgt = '0;
    ex_flush    = 1'b0;
    state_d     = state_q;
    pend_tgt_d  = pend_tgt_q;
    load_inst   = 1'b0;
    load_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (rst) begin
      pc_en    = 1'b0;
      stall_en = 1'b1;
      ex_flush = 1'b1;
    end else if (mem_busy) begin
      // Whole pipeline frozen; a branch resolving now must wait for the thaw.
      pc_en     = 1'b0;
      stall_en  = 1'b1;
      stall_inc = 1'b1;
      if ((state_q == RUN) && ex_bch_taken) begin
        pend_tgt_d = ex_bch_tgt;
        state_d    = PEND;
      end
    end else if (state_q == PEND) begin
      jmp_bch_en  = 1'b1;
      jmp_bch_tgt = pend_tgt_q;
      stall_en    = 1'b1;
      ex_flush    = 1'b1;
      load_bubble = 1'b1;
      flush_inc   = 1'b1;
      state_d     = RUN;
    end else if (ex_bch_taken) begin
      // Redirect wins over load-use: the stalled instruction is squashed anyway.
      jmp_bch_en  = 1'b1;
      jmp_bch_tgt = ex_bch_tgt;
      stall_en    = 1'b1;
      ex_flush    = 1'b1;
      load_bubble = 1'b1;
      flush_inc   = 1'b1;
    end else if (lu) begin
      pc_en     = 1'b0;
      ex_flush  = 1'b1;
      stall_inc = 1'b1;
    end else begin
      load_inst = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pend_tgt_q  <= '0;
      id_inst_q   <= nop;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      if (load_bubble) begin
        id_inst_q  <= nop;
        id_pc_q    <= if_pc;
        id_valid_q <= 1'b0;
      end else if (load_inst) begin
        id_inst_q  <= if_inst;
        id_pc_q    <= if_pc;
        id_valid_q <= 1'b1;
      end
      if (stall_inc && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + cnt_width'(1);
      if (flush_inc && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + cnt_width'(1);
    end
  end

  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/if_id_ctrl.md
# if_id_ctrl

Front-end control and IF/ID pipeline register: the consumer of the fetch stage's `inst`/`pc_addr` outputs and the sole driver of its `pc_en`, `stall_en`, `jmp_bch_en` and `jmp_bch_tgt` controls. It captures fetched instructions into the IF/ID register. It resolves load-use hazards, taken branches/jumps from EX and memory-busy freezes into PC-enable, redirect and squash actions. A branch that resolves during a freeze is held as a pending redirect until the freeze ends. Saturating stall and flush counters are provided for performance analysis.

## Interface
- `addr_width`, default `MEM_ADDR_WIDTH`: PC / branch target width.
- `word_width`, default `WORD_WIDTH`: instruction width.
- `cnt_width`, default 16: performance counter width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_inst`  in  word_width  instruction from fetch stage.
- `if_pc`  in  addr_width  PC of `if_inst`.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  instruction in ID reads that source.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_bch_taken`  in  1  single-cycle pulse: branch/jump in EX is taken.
- `ex_bch_tgt`  in  addr_width  target; valid with `ex_bch_taken`.
- `mem_busy`  in  1  data memory busy; entire pipeline frozen this cycle.
- `pc_en`, `stall_en`, `jmp_bch_en`  out  1 each  fetch-stage controls.
- `jmp_bch_tgt`  out  addr_width  redirect target.
- `id_inst`  out  word_width  IF/ID instruction (registered).
- `id_pc`  out  addr_width  IF/ID PC (registered).
- `id_valid`  out  1  IF/ID holds a real instruction (registered).
- `ex_flush`  out  1  ID/EX must load a bubble this cycle.
- `stall_cnt`, `flush_cnt`  out  cnt_width  saturating performance counters.

## Operation
- NOP = `ADDI x0,x0,0` (0x00000013).
- States: RUN, PEND (redirect latched, waiting for `mem_busy` to fall).
- Hazard `lu` = `ex_mem_read` & `ex_rd`!=0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)) & `id_valid`.
- Per-cycle action, by priority (combinational outputs, register update at edge):
  1. `rst`: `pc_en`=0, `stall_en`=1, `jmp_bch_en`=0, `jmp_bch_tgt`=0, `ex_flush`=1; regs reset.
  2. `mem_busy`: `pc_en`=0, `jmp_bch_en`=0, `ex_flush`=0, IF/ID holds. If `ex_bch_taken` in RUN: latch `ex_bch_tgt` into `pend_tgt`, go PEND. `stall_cnt`++.
  3. PEND & !`mem_busy`: `jmp_bch_en`=1, `jmp_bch_tgt`=`pend_tgt`, `pc_en`=1, `stall_en`=1, `ex_flush`=1; IF/ID <= {NOP, `if_pc`, 0}; go RUN; `flush_cnt`++.
  4. RUN & `ex_bch_taken`: same as 3, using `ex_bch_tgt`; `lu` ignored.
  5. RUN & `lu`: `pc_en`=0, `stall_en`=0, `ex_flush`=1, IF/ID holds; `stall_cnt`++.
  6. Otherwise: `pc_en`=1, `stall_en`=0, `ex_flush`=0, IF/ID <= {`if_inst`, `if_pc`, 1}.
- `jmp_bch_tgt` is 0 whenever `jmp_bch_en`=0.
- `ex_bch_taken` in PEND is ignored; the first target wins.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset values: `id_inst`=NOP, `id_pc`=0, `id_valid`=0, state RUN, `pend_tgt`=0, counters 0.
- Redirect latency: `ex_bch_taken` in cycle N → PC=target after edge N; target instruction is in ID at N+2. Penalty is 2 bubbles.
- Load-use: exactly one stall cycle per hazard. In cycle N+1 the load has left EX and `lu` drops.
- A freeze started and ended around a branch delays the redirect until the first cycle with `mem_busy`=0.
- `rst` asserted in PEND discards the pending redirect.

## Test plan
- Reset, then straight-line fetch of PCs 0,4,8 → `id_pc` 0,4,8 one cycle later, `id_valid`=1, `pc_en`=1 every cycle.
- Load x5 in EX with ID `id_rs1`=5, `id_use_rs1`=1 → one cycle with `pc_en`=0, `ex_flush`=1, IF/ID unchanged, `stall_cnt`=1. Same case with `ex_rd`=0 → no stall.
- `ex_bch_taken` with target 0x40 at PC 0x10 → `jmp_bch_en`=1, tgt=0x40, `id_valid`=0 next cycle, `id_pc`=0x40 two cycles later, `flush_cnt`=1.
- `mem_busy` for 3 cycles with `ex_bch_taken` (tgt 0x80) in the first busy cycle → `pc_en`=0 for 3 cycles, redirect to 0x80 in the first non-busy cycle, `stall_cnt`=3.
- Branch and load-use in the same cycle → redirect only, `stall_cnt` unchanged. `rst` asserted during PEND → no redirect after reset.
- Force 2^cnt_width+5 stall cycles → `stall_cnt` holds 0xFFFF.
